pulse_voice_alloc: RTL and testbench

- Voice allocator/scheduler for the pulse channels: takes a stream of MIDI note events and decides which channel plays each note.
- Per-voice outputs are note_on / note_start / note_repeat, driving one duty_switch instance and one pulse-channel frequency path per voice.
- Sits between the MIDI parser and the per-channel sound logic.
- Policy: retrigger a voice already holding the note, else take the lowest free voice, else steal the oldest voice.

---
 rtl/gb_midi_pkg.sv | 29 ++
 rtl/voice_slot.sv | 55 +++++
 rtl/pulse_voice_alloc.sv | 186 ++++++++++++++++++
 tb/tb_pulse_voice_alloc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gb_midi_pkg.sv
// Shared types for the MIDI-driven pulse-voice logic: note/velocity widths,
// the allocator FSM states and the per-voice register layout.
package gb_midi_pkg;

  localparam int NOTE_W    = 7;
  localparam int VEL_W     = 7;
  // Storage width of the age field; a slot saturates at its own (smaller) limit.
  localparam int AGE_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } alloc_state_t;

  typedef struct packed {
    logic                 on;
    logic [NOTE_W-1:0]    note;
    logic [VEL_W-1:0]     vel;
    logic [AGE_MAX_W-1:0] age;
  } voice_t;

  // Increment that sticks at age_max instead of wrapping.
  function automatic logic [AGE_MAX_W-1:0] age_sat_inc(input logic [AGE_MAX_W-1:0] age,
                                                       input logic [AGE_MAX_W-1:0] age_max);
    return (age >= age_max) ? age_max : age + AGE_MAX_W'(1);
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One pulse voice: gate/note/velocity/age register with load (new or stolen
// note), retrigger (same note, new velocity), release, saturating aging and
// a panic clear. retrig_pulse is high for the single clock after a retrigger.
module voice_slot
  import gb_midi_pkg::*;
#(
  parameter int AGE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic              retrig,
  input  logic              rel,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] new_note,
  input  logic [VEL_W-1:0]  new_vel,
  output voice_t            voice,
  output logic              retrig_pulse
);

  localparam logic [AGE_MAX_W-1:0] AGE_MAX = AGE_MAX_W'((1 << AGE_W) - 1);

  voice_t voice_reg;
  logic   retrig_pulse_reg;

  // Voice state update; clear wins, then the one-hot apply commands, then aging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      voice_reg        <= '0;
      retrig_pulse_reg <= 1'b0;
    end else begin
      retrig_pulse_reg <= en & ~clr & retrig;
      if (en) begin
        if (clr) begin
          voice_reg <= '0;
        end else if (load) begin
          voice_reg <= '{on: 1'b1, note: new_note, vel: new_vel, age: '0};
        end else if (retrig) begin
          voice_reg.vel <= new_vel;
          voice_reg.age <= '0;
        end else if (rel) begin
          voice_reg <= '0;
        end else if (age_inc && voice_reg.on) begin
          voice_reg.age <= age_sat_inc(voice_reg.age, AGE_MAX);
        end
      end
    end
  end

  assign voice        = voice_reg;
  assign retrig_pulse = retrig_pulse_reg;

endmodule

// File: rtl/pulse_voice_alloc.sv
// Pulse-voice allocator: accepts note events, scans the voices one per
// enabled cycle, then retriggers a voice holding the note, takes the lowest
// free voice, or steals the oldest one.
module pulse_voice_alloc
  import gb_midi_pkg::*;
#(
  parameter int NUM_VOICES = 2,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         all_off,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  output logic [NUM_VOICES-1:0]        voice_on,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic [NUM_VOICES-1:0]        voice_repeat,
  output logic                         busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_t         state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 cap_on_reg, cap_on_next;
  logic [NOTE_W-1:0]    cap_note_reg, cap_note_next;
  logic [VEL_W-1:0]     cap_vel_reg, cap_vel_next;
  logic                 match_found_reg, match_found_next;
  logic [IDX_W-1:0]     match_idx_reg, match_idx_next;
  logic                 free_found_reg, free_found_next;
  logic [IDX_W-1:0]     free_idx_reg, free_idx_next;
  logic                 old_found_reg, old_found_next;
  logic [IDX_W-1:0]     old_idx_reg, old_idx_next;
  logic [AGE_MAX_W-1:0] old_age_reg, old_age_next;

  voice_t           voices [NUM_VOICES];
  voice_t           cur;
  logic             apply_fire;
  logic [IDX_W-1:0] target_idx;

  assign ev_ready   = en & ~all_off & (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign cur        = voices[idx_reg];
  assign apply_fire = en & ~all_off & (state_reg == APPLY);

  // Voice chosen by the apply step: match first, then lowest free, then oldest.
  always_comb begin
    target_idx = match_idx_reg;
    if (cap_on_reg && !match_found_reg) begin
      target_idx = free_found_reg ? free_idx_reg : old_idx_reg;
    end
  end

  // Next-state logic: capture in IDLE, one voice per cycle in SCAN, APPLY returns to IDLE.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    cap_on_next      = cap_on_reg;
    cap_note_next    = cap_note_reg;
    cap_vel_next     = cap_vel_reg;
    match_found_next = match_found_reg;
    match_idx_next   = match_idx_reg;
    free_found_next  = free_found_reg;
    free_idx_next    = free_idx_reg;
    old_found_next   = old_found_reg;
    old_idx_next     = old_idx_reg;
    old_age_next     = old_age_reg;
    if (all_off) begin
      state_next = IDLE;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ev_valid) begin
            // A note-on with zero velocity is treated as a note-off.
            cap_on_next      = ev_on & (ev_vel != '0);
            cap_note_next    = ev_note;
            cap_vel_next     = ev_vel;
            match_found_next = 1'b0;
            match_idx_next   = '0;
            free_found_next  = 1'b0;
            free_idx_next    = '0;
            old_found_next   = 1'b0;
            old_idx_next     = '0;
            old_age_next     = '0;
            idx_next         = '0;
            state_next       = SCAN;
          end
        end
        SCAN: begin
          if (!match_found_reg && cur.on && (cur.note == cap_note_reg)) begin
            match_found_next = 1'b1;
            match_idx_next   = idx_reg;
          end
          if (!free_found_reg && !cur.on) begin
            free_found_next = 1'b1;
            free_idx_next   = idx_reg;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (cur.on && (!old_found_reg || (cur.age > old_age_reg))) begin
            old_found_next = 1'b1;
            old_idx_next   = idx_reg;
            old_age_next   = cur.age;
          end
          if (idx_reg == LAST_IDX) begin
            state_next = APPLY;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        APPLY: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and scan-result registers advance only on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      cap_on_reg      <= 1'b0;
      cap_note_reg    <= '0;
      cap_vel_reg     <= '0;
      match_found_reg <= 1'b0;
      match_idx_reg   <= '0;
      free_found_reg  <= 1'b0;
      free_idx_reg    <= '0;
      old_found_reg   <= 1'b0;
      old_idx_reg     <= '0;
      old_age_reg     <= '0;
    end else if (en) begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cap_on_reg      <= cap_on_next;
      cap_note_reg    <= cap_note_next;
      cap_vel_reg     <= cap_vel_next;
      match_found_reg <= match_found_next;
      match_idx_reg   <= match_idx_next;
      free_found_reg  <= free_found_next;
      free_idx_reg    <= free_idx_next;
      old_found_reg   <= old_found_next;
      old_idx_reg     <= old_idx_next;
      old_age_reg     <= old_age_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic is_tgt;
      assign is_tgt = (target_idx == IDX_W'(gi));

      voice_slot #(
        .AGE_W(AGE_W)
      ) u_slot (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .clr          (all_off),
        .load         (apply_fire & cap_on_reg & ~match_found_reg & is_tgt),
        .retrig       (apply_fire & cap_on_reg & match_found_reg & is_tgt),
        .rel          (apply_fire & ~cap_on_reg & match_found_reg & is_tgt),
        .age_inc      (apply_fire & cap_on_reg & ~is_tgt),
        .new_note     (cap_note_reg),
        .new_vel      (cap_vel_reg),
        .voice        (voices[gi]),
        .retrig_pulse (voice_repeat[gi])
      );

      assign voice_on[gi]                   = voices[gi].on;
      assign voice_note[NOTE_W*gi +: NOTE_W] = voices[gi].note;
      assign voice_vel[VEL_W*gi +: VEL_W]    = voices[gi].vel;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_voice_alloc.sv
// Directed bench for the two-voice allocator: table of events with expected
// voice state, plus sequences for panic, clock-enable gating and reset.
module tb_pulse_voice_alloc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        all_off;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [6:0]  ev_vel;
  logic [1:0]  voice_on;
  logic [13:0] voice_note;
  logic [13:0] voice_vel;
  logic [1:0]  voice_repeat;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int k;

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic [1:0] x_on;
    logic [6:0] x_n0;
    logic [6:0] x_v0;
    logic [6:0] x_n1;
    logic [6:0] x_v1;
    logic [1:0] x_rep;
  } vec_t;

  vec_t tbl [12];

  pulse_voice_alloc #(.NUM_VOICES(2), .AGE_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .all_off      (all_off),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .ev_vel       (ev_vel),
    .voice_on     (voice_on),
    .voice_note   (voice_note),
    .voice_vel    (voice_vel),
    .voice_repeat (voice_repeat),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic on, input logic [6:0] note, input logic [6:0] vel,
                              input logic [1:0] x_on, input logic [6:0] x_n0, input logic [6:0] x_v0,
                              input logic [6:0] x_n1, input logic [6:0] x_v1, input logic [1:0] x_rep);
    vec_t v;
    v.on = on; v.note = note; v.vel = vel;
    v.x_on = x_on; v.x_n0 = x_n0; v.x_v0 = x_v0; v.x_n1 = x_n1; v.x_v1 = x_v1; v.x_rep = x_rep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one event at a negedge; return after the accepting posedge + negedge.
  task automatic present(input logic on, input logic [6:0] note, input logic [6:0] vel);
    ev_on = on; ev_note = note; ev_vel = vel; ev_valid = 1'b1;
    chk("ready_before_accept", 32'(ev_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; all_off = 1'b0; ev_valid = 1'b0;
    ev_on = 1'b0; ev_note = '0; ev_vel = '0;

    tbl[0]  = mk(1'b1, 7'd60, 7'd100, 2'b01, 7'd60, 7'd100, 7'd0,  7'd0,  2'b00); // lowest free
    tbl[1]  = mk(1'b1, 7'd64, 7'd90,  2'b11, 7'd60, 7'd100, 7'd64, 7'd90, 2'b00); // next free
    tbl[2]  = mk(1'b1, 7'd67, 7'd80,  2'b11, 7'd67, 7'd80,  7'd64, 7'd90, 2'b00); // steal v0 (older)
    tbl[3]  = mk(1'b1, 7'd60, 7'd50,  2'b11, 7'd67, 7'd80,  7'd60, 7'd50, 2'b00); // steal v1 (aged)
    tbl[4]  = mk(1'b1, 7'd67, 7'd55,  2'b11, 7'd67, 7'd55,  7'd60, 7'd50, 2'b01); // retrigger v0
    tbl[5]  = mk(1'b1, 7'd60, 7'd70,  2'b11, 7'd67, 7'd55,  7'd60, 7'd70, 2'b10); // retrigger v1
    tbl[6]  = mk(1'b0, 7'd60, 7'd0,   2'b01, 7'd67, 7'd55,  7'd0,  7'd0,  2'b00); // off v1
    tbl[7]  = mk(1'b0, 7'd72, 7'd0,   2'b01, 7'd67, 7'd55,  7'd0,  7'd0,  2'b00); // off not held
    tbl[8]  = mk(1'b1, 7'd60, 7'd0,   2'b01, 7'd67, 7'd55,  7'd0,  7'd0,  2'b00); // vel0 not held
    tbl[9]  = mk(1'b1, 7'd72, 7'd10,  2'b11, 7'd67, 7'd55,  7'd72, 7'd10, 2'b00); // free v1
    tbl[10] = mk(1'b1, 7'd72, 7'd0,   2'b01, 7'd67, 7'd55,  7'd0,  7'd0,  2'b00); // vel0 = off
    tbl[11] = mk(1'b1, 7'd64, 7'd90,  2'b11, 7'd67, 7'd55,  7'd64, 7'd90, 2'b00);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_voice_on", 32'(voice_on), 32'd0);
    chk("rst_voice_note", 32'(voice_note), 32'd0);
    chk("rst_voice_vel", 32'(voice_vel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven events
    for (int i = 0; i < 12; i++) begin
      present(tbl[i].on, tbl[i].note, tbl[i].vel);
      k = 0;
      while (!ev_ready && k < 20) begin
        @(posedge clk); @(negedge clk); k++;
      end
      $display("ev %0d: on=%0d note=%0d vel=%0d -> voice_on=%b n0=%0d v0=%0d n1=%0d v1=%0d rep=%b accept_period=%0d",
               i, tbl[i].on, tbl[i].note, tbl[i].vel, voice_on, voice_note[6:0], voice_vel[6:0],
               voice_note[13:7], voice_vel[13:7], voice_repeat, k + 1);
      chk("accept_period", 32'(k + 1), 32'd4);
      chk("voice_on", 32'(voice_on), 32'(tbl[i].x_on));
      chk("note0", 32'(voice_note[6:0]), 32'(tbl[i].x_n0));
      chk("vel0", 32'(voice_vel[6:0]), 32'(tbl[i].x_v0));
      chk("note1", 32'(voice_note[13:7]), 32'(tbl[i].x_n1));
      chk("vel1", 32'(voice_vel[13:7]), 32'(tbl[i].x_v1));
      chk("repeat", 32'(voice_repeat), 32'(tbl[i].x_rep));
      chk("busy_idle", 32'(busy), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("repeat_one_clk", 32'(voice_repeat), 32'd0);
    end

    // Panic during SCAN of note 70 with both voices held
    present(1'b1, 7'd70, 7'd30);
    @(posedge clk); @(negedge clk);
    all_off = 1'b1;
    #1;
    chk("alloff_ready_low", 32'(ev_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    all_off = 1'b0;
    #1;
    $display("all_off during scan: voice_on=%b busy=%0d ev_ready=%0d", voice_on, busy, ev_ready);
    chk("alloff_voice_on", 32'(voice_on), 32'd0);
    chk("alloff_notes", 32'(voice_note), 32'd0);
    chk("alloff_busy", 32'(busy), 32'd0);
    chk("alloff_ready_back", 32'(ev_ready), 32'd1);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("alloff_event_dropped", 32'(voice_on), 32'd0);

    // Panic coinciding with a valid event: not accepted
    ev_on = 1'b1; ev_note = 7'd80; ev_vel = 7'd40; ev_valid = 1'b1; all_off = 1'b1;
    #1;
    chk("alloff_valid_ready", 32'(ev_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    ev_valid = 1'b0; all_off = 1'b0;
    #1;
    $display("all_off with ev_valid: busy=%0d voice_on=%b", busy, voice_on);
    chk("alloff_valid_busy", 32'(busy), 32'd0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("alloff_valid_voice_on", 32'(voice_on), 32'd0);

    // Clock enable toggling every clock
    present(1'b1, 7'd60, 7'd100);
    en = 1'b0;
    k = 0;
    while (!(voice_on[0] && !busy) && k < 30) begin
      @(posedge clk); @(negedge clk); k++;
      if (!(voice_on[0] && !busy)) en = ~en;
    end
    $display("en toggle: applied after %0d clks, n0=%0d", k, voice_note[6:0]);
    chk("en_latency_clks", 32'(k), 32'd6);
    chk("en_note0", 32'(voice_note[6:0]), 32'd60);
    en = 1'b1;
    @(negedge clk);

    // Reset pulsed mid-SCAN
    present(1'b1, 7'd62, 7'd20);
    @(posedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    $display("reset mid-scan: voice_on=%b busy=%0d", voice_on, busy);
    chk("rstmid_voice_on", 32'(voice_on), 32'd0);
    chk("rstmid_note", 32'(voice_note), 32'd0);
    chk("rstmid_vel", 32'(voice_vel), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    present(1'b1, 7'd61, 7'd5);
    k = 0;
    while (!ev_ready && k < 20) begin
      @(posedge clk); @(negedge clk); k++;
    end
    $display("after reset: voice_on=%b n0=%0d v0=%0d", voice_on, voice_note[6:0], voice_vel[6:0]);
    chk("recover_period", 32'(k + 1), 32'd4);
    chk("recover_voice_on", 32'(voice_on), 32'd1);
    chk("recover_note0", 32'(voice_note[6:0]), 32'd61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
